// File: rtl/gemm_pkg.sv
// Shared constants, FSM state type and address type for the GEMM sequencer.
// The optional GEMM_SEQ_PERF_EN counters use the saturating helper below.
package gemm_pkg;

    localparam int GEMM_ADDR_W   = 7;
    localparam int GEMM_PIPE_LAT = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_FIN
    } gemm_state_e;

    typedef logic [GEMM_ADDR_W-1:0] gemm_addr_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/gemm_seq_vpipe.sv
// Valid/address delay line matching the BRAM + multiply-add latency.
// The whole line freezes on hold; the head entry is masked off while held.
module gemm_seq_vpipe #(
    parameter int PIPE_LAT = 4,
    parameter int ADDR_W   = 7
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              hold,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic              pending
);

    logic [PIPE_LAT-1:0] r_valid;
    logic [ADDR_W-1:0]   r_addr [PIPE_LAT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_addr[i] <= '0;
            end
        end else if (!hold) begin
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                r_valid[i] <= r_valid[i-1];
                r_addr[i]  <= r_addr[i-1];
            end
            r_valid[0] <= in_valid;
            r_addr[0]  <= in_addr;
        end
    end

    assign out_valid = r_valid[PIPE_LAT-1] & ~hold;
    assign out_addr  = r_addr[PIPE_LAT-1];

    // Entries still in flight behind the one currently at the output.
    generate
        if (PIPE_LAT > 1) begin : g_pend
            assign pending = |r_valid[PIPE_LAT-2:0];
        end else begin : g_nopend
            assign pending = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/gemm_seq_ctrl.sv
// Address sequencer for a GEMM pass: issues start..end (wrapping) to the BRAMs,
// tracks results through the delay line. Optional counters: GEMM_SEQ_PERF_EN.
module gemm_seq_ctrl
    import gemm_pkg::*;
#(
    parameter int ADDR_W   = GEMM_ADDR_W,
    parameter int PIPE_LAT = GEMM_PIPE_LAT
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              hold,
    output logic              rd_en,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] inaddr,
    output logic              res_valid,
    output logic [ADDR_W-1:0] res_addr,
    output logic              busy,
    output logic              done
`ifdef GEMM_SEQ_PERF_EN
    ,
    output logic [15:0]       stall_cycles,
    output logic [15:0]       pass_cycles
`endif
);

    gemm_state_e       r_state;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_start_addr;
    logic [ADDR_W-1:0] r_end_addr;
    logic              r_busy;
    logic              r_done;
    logic              w_pending;
    logic              w_accept;

    assign w_accept = (r_state == ST_IDLE) && start;

    // The counter itself is the presented address; an issue happens in any
    // cycle where it is armed and not held, so a held address is replayed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_rd_en      <= 1'b0;
            r_cnt        <= '0;
            r_start_addr <= '0;
            r_end_addr   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_start_addr <= start_addr;
                        r_end_addr   <= end_addr;
                        r_cnt        <= start_addr;
                        r_done       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_rd_en      <= 1'b1;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!hold) begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                        if (r_cnt == r_end_addr) begin
                            r_rd_en <= 1'b0;
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Leave once the entry at the output is the last one and it is taken.
                    if (!hold && !w_pending) begin
                        r_state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rd_en  = r_rd_en & ~hold;
    assign waddr  = r_cnt;
    assign inaddr = r_cnt;
    assign busy   = r_busy;
    assign done   = r_done;

    gemm_seq_vpipe #(
        .PIPE_LAT (PIPE_LAT),
        .ADDR_W   (ADDR_W)
    ) u_vpipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_en),
        .in_addr   (r_cnt),
        .hold      (hold),
        .out_valid (res_valid),
        .out_addr  (res_addr),
        .pending   (w_pending)
    );

`ifdef GEMM_SEQ_PERF_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_pass_cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_pass_cycles  <= '0;
        end else if (w_accept) begin
            r_stall_cycles <= '0;
            r_pass_cycles  <= '0;
        end else if (r_busy) begin
            r_pass_cycles <= sat_inc16(r_pass_cycles);
            if (hold) begin
                r_stall_cycles <= sat_inc16(r_stall_cycles);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign pass_cycles  = r_pass_cycles;
`endif

    // Start address only seeds the counter; kept for debug visibility.
    logic w_unused;
    assign w_unused = ^r_start_addr;

endmodule

// File: tb/tb_gemm_seq_ctrl.sv
// Testbench for gemm_seq_ctrl: table of passes plus reset-in-DRAIN sequence.
// Expected issue/result addresses are queued at start and popped by a monitor.
module tb_gemm_seq_ctrl;
    import gemm_pkg::*;

    localparam int AW  = GEMM_ADDR_W;
    localparam int LAT = GEMM_PIPE_LAT;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    gemm_addr_t start_addr;
    gemm_addr_t end_addr;
    logic       hold;
    logic       rd_en;
    gemm_addr_t waddr;
    gemm_addr_t inaddr;
    logic       res_valid;
    gemm_addr_t res_addr;
    logic       busy;
    logic       done;
`ifdef GEMM_SEQ_PERF_EN
    logic [15:0] stall_cycles;
    logic [15:0] pass_cycles;
`endif

    gemm_seq_ctrl #(.ADDR_W(AW), .PIPE_LAT(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .hold       (hold),
        .rd_en      (rd_en),
        .waddr      (waddr),
        .inaddr     (inaddr),
        .res_valid  (res_valid),
        .res_addr   (res_addr),
        .busy       (busy),
        .done       (done)
`ifdef GEMM_SEQ_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .pass_cycles  (pass_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        gemm_addr_t s;
        gemm_addr_t e;
        int         exp_n;
        int         hold_at;
        int         hold_len;
        int         mid_start;
    } vec_t;

    vec_t       vecs [6];
    int         n_checks = 0;
    int         n_fail   = 0;
    gemm_addr_t exp_iss_q [$];
    gemm_addr_t exp_res_q [$];
    int         iss_time_q [$];
    int         unheld     = 0;
    int         n_issued   = 0;
    int         n_results  = 0;
    int         done_rises = 0;
    logic       prev_done  = 1'b0;
    bit         mon_en     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (!hold) unheld++;
            if (hold) begin
                check("rd_en_during_hold", rd_en, 0);
                check("res_valid_during_hold", res_valid, 0);
            end
            if (rd_en) begin
                n_issued++;
                if (exp_iss_q.size() == 0) begin
                    fail_now("unexpected_issue");
                end else begin
                    gemm_addr_t e;
                    e = exp_iss_q.pop_front();
                    check("waddr", waddr, e);
                    check("inaddr", inaddr, e);
                    iss_time_q.push_back(unheld);
                end
            end
            if (res_valid) begin
                n_results++;
                if (exp_res_q.size() == 0) begin
                    fail_now("unexpected_result");
                end else begin
                    check("res_addr", res_addr, exp_res_q.pop_front());
                end
                if (iss_time_q.size() != 0) begin
                    check("latency", unheld - iss_time_q.pop_front(), LAT);
                end
            end
            if (done && !prev_done) done_rises++;
            prev_done = done;
        end
    end

    task automatic run_pass(input vec_t v);
        gemm_addr_t a;
        int cyc;
        int held;
        @(posedge clk); #1;
        n_issued   = 0;
        n_results  = 0;
        done_rises = 0;
        a = v.s;
        for (int i = 0; i < v.exp_n; i++) begin
            exp_iss_q.push_back(a);
            exp_res_q.push_back(a);
            a = a + 1'b1;
        end
        start      = 1'b1;
        start_addr = v.s;
        end_addr   = v.e;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 0;
        held  = 0;
        while (done !== 1'b1 && cyc < 2000) begin
            if (v.hold_len > 0 && n_issued == v.hold_at && held < v.hold_len) begin
                hold = 1'b1;
                held++;
            end else begin
                hold = 1'b0;
            end
            if (cyc == v.mid_start) begin
                start      = 1'b1;
                start_addr = 7'd50;
                end_addr   = 7'd60;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        hold  = 1'b0;
        start = 1'b0;
        if (cyc >= 2000) fail_now("pass_timeout");
        check("pass_len", cyc, v.exp_n + LAT + v.hold_len + 1);
`ifdef GEMM_SEQ_PERF_EN
        check("stall_cycles", stall_cycles, v.hold_len);
        check("pass_cycles", pass_cycles, v.exp_n + LAT + v.hold_len + 1);
`endif
        repeat (6) @(negedge clk);
        #1;
        check("result_count", n_results, v.exp_n);
        check("issue_count", n_issued, v.exp_n);
        check("done_once", done_rises, 1);
        check("done_sticky", done, 1);
        check("busy_after", busy, 0);
        check("res_q_left", exp_res_q.size(), 0);
        $display("pass %0d..%0d: %0d results in %0d busy cycles", v.s, v.e, n_results, cyc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{7'd3,   7'd6,   4,  0, 0, -1};
        vecs[1] = '{7'd126, 7'd1,   4,  0, 0, -1};
        vecs[2] = '{7'd5,   7'd5,   1,  0, 0, -1};
        vecs[3] = '{7'd100, 7'd20,  49, 0, 0, -1};
        vecs[4] = '{7'd0,   7'd9,   10, 5, 3, -1};
        vecs[5] = '{7'd0,   7'd9,   10, 0, 0, 3};

        reset      = 1'b1;
        start      = 1'b0;
        hold       = 1'b0;
        start_addr = '0;
        end_addr   = '0;
        #12;
        check("rst_rd_en", rd_en, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_waddr", waddr, 0);
        @(posedge clk); #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_pass(vecs[i]);
        end

        // Start held in IDLE is accepted; first issue waits for hold to drop.
        @(posedge clk); #1;
        n_issued   = 0;
        n_results  = 0;
        for (int i = 0; i < 10; i++) begin
            exp_iss_q.push_back(gemm_addr_t'(i));
            exp_res_q.push_back(gemm_addr_t'(i));
        end
        start = 1'b1; hold = 1'b1; start_addr = 7'd0; end_addr = 7'd9;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_start_hold", busy, 1);
        @(posedge clk); #1;
        check("no_issue_held", n_issued, 0);
        hold = 1'b0;
        for (int c = 0; c < 100 && n_issued < 10; c++) begin
            @(posedge clk); #1;
        end
        check("issued_before_reset", n_issued, 10);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("rr_rd_en", rd_en, 0);
        check("rr_res_valid", res_valid, 0);
        check("rr_busy", busy, 0);
        check("rr_done", done, 0);
        check("rr_waddr", waddr, 0);
        check("rr_inaddr", inaddr, 0);
        check("rr_res_addr", res_addr, 0);
        exp_iss_q.delete();
        exp_res_q.delete();
        iss_time_q.delete();
        @(posedge clk); #1;
        reset      = 1'b0;
        n_results  = 0;
        done_rises = 0;
        repeat (12) @(posedge clk);
        #1;
        check("abandoned_results", n_results, 0);
        check("abandoned_done", done, 0);
        $display("reset during drain: results after reset %0d", n_results);

        run_pass(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
